uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_serializer.sv | 43 ++++
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: Gray-coded FSM states,
// payload width default and a prescale normalisation helper.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_START  = 3'b001;
  localparam logic [2:0] ST_DATA   = 3'b011;
  localparam logic [2:0] ST_PARITY = 3'b010;
  localparam logic [2:0] ST_STOP   = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  // A latched prescale of zero behaves as one clock per bit.
  function automatic logic [5:0] norm_prescale(input logic [5:0] p);
    return (p == 6'd0) ? 6'd1 : p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter; LSB leaves first, and the
// bit that follows the current one is exposed so the line can be registered.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_shift,
  output logic                  o_bit,
  output logic                  o_next_bit,
  output logic                  o_last
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_bcnt;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_shifted = r_shift >> 1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_bcnt  <= '0;
    end else if (i_shift) begin
      r_shift <= w_shifted;
      r_bcnt  <= r_bcnt + CW'(1);
    end
  end

  assign o_bit      = r_shift[0];
  assign o_next_bit = w_shifted[0];
  assign o_last     = (r_bcnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, one stop
// bit, each held for a latched prescale of clocks. TX_OUT and Busy are flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic [2:0]            o_dbg_state
);

  // Request handshake: DATA_VALID is a one-sided request sampled only while
  // IDLE; the edge that sees it there is the acceptance edge. There is no
  // ready signal and no queueing, so requests seen while Busy are dropped.

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;
  logic [5:0] r_presc;
  logic       r_par_en;
  logic       r_par_bit;
  logic       r_tx, w_tx_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_load;
  logic       w_shift;
  logic       w_bit_end;
  logic       w_ser_bit;
  logic       w_ser_next;
  logic       w_ser_last;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_data     (P_DATA),
    .i_shift    (w_shift),
    .o_bit      (w_ser_bit),
    .o_next_bit (w_ser_next),
    .o_last     (w_ser_last)
  );

  assign w_bit_end = (r_cnt == r_presc - 6'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_presc   <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      if (w_load) begin
        r_presc   <= norm_prescale(PRESCALE);
        r_par_en  <= PAR_EN;
        r_par_bit <= (^P_DATA) ^ PAR_TYP;
      end
    end
  end

  // Outputs are computed one edge early so the line and Busy come from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (DATA_VALID) begin
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DATA;
          w_tx_nxt    = w_ser_bit;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (!w_ser_last) begin
            w_shift  = 1'b1;
            w_tx_nxt = w_ser_next;
          end else if (r_par_en) begin
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par_bit;
          end else begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign TX_OUT      = r_tx;
  assign Busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level line model is compared every cycle, and
// directed frames are captured and checked against hand-derived waveforms.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic       TX_OUT;
  logic       Busy;
  logic [2:0] o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  uart_tx dut (
    .CLK         (CLK),
    .RST         (RST),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .PRESCALE    (PRESCALE),
    .TX_OUT      (TX_OUT),
    .Busy        (Busy),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Line model: on acceptance the whole frame is expanded into per-cycle
  // line levels; each edge pops one, and an empty queue means idle.
  logic exp_q[$];
  logic m_tx   = 1'b1;
  logic m_busy = 1'b0;
  logic m_frame[0:11];
  int   m_p;
  int   m_n;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      if (!m_busy && DATA_VALID) begin
        m_p = (PRESCALE == 6'd0) ? 1 : int'(PRESCALE);
        m_frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_frame[i+1] = P_DATA[i];
        m_n = 9;
        if (PAR_EN) begin
          m_frame[m_n] = (^P_DATA) ^ PAR_TYP;
          m_n++;
        end
        m_frame[m_n] = 1'b1;
        m_n++;
        for (int b = 0; b < m_n; b++)
          for (int c = 0; c < m_p; c++) exp_q.push_back(m_frame[b]);
      end
      if (exp_q.size() > 0) begin
        m_tx   = exp_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // Scoreboard compare, every cycle out of reset
  always @(negedge CLK) begin
    if (!RST) begin
      n_vec++;
      if (TX_OUT !== m_tx || Busy !== m_busy) begin
        n_err++;
        $display("FAIL line_model t=%0t: tx=%b busy=%b want tx=%b busy=%b",
                 $time, TX_OUT, Busy, m_tx, m_busy);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  logic cap[0:255];
  int   cap_n;

  task automatic capture(input bit noise);
    cap_n = 0;
    while (Busy && cap_n < 200) begin
      cap[cap_n] = TX_OUT;
      cap_n++;
      if (noise) begin
        DATA_VALID = 1'($urandom_range(0, 1));
        P_DATA     = 8'($urandom_range(0, 255));
        PRESCALE   = 6'($urandom_range(0, 63));
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] ps, input bit noise);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = ps; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    capture(noise);
  endtask

  function automatic logic [15:0] pack_cap(input int n, input int stride);
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[14:0], cap[i*stride]};
    return v;
  endfunction

  int held_err;
  int len;

  initial begin
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    PRESCALE = 6'd1;
    repeat (2) @(negedge CLK);
    check("reset_tx", 32'(TX_OUT), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 0xA5, no parity, one clock per bit
    send(8'hA5, 1'b0, 1'b0, 6'd1, 1'b0);
    check("a5_len", 32'(cap_n), 32'd10);
    check("a5_bits", 32'(pack_cap(10, 1)), 32'(10'b0101001011));

    send(8'hA5, 1'b1, 1'b0, 6'd1, 1'b0);
    check("a5_even_len", 32'(cap_n), 32'd11);
    check("a5_even_par", 32'(cap[9]), 32'd0);
    send(8'hA5, 1'b1, 1'b1, 6'd1, 1'b0);
    check("a5_odd_par", 32'(cap[9]), 32'd1);

    // 0x3C, odd parity, eight clocks per bit
    send(8'h3C, 1'b1, 1'b1, 6'd8, 1'b0);
    check("3c_len", 32'(cap_n), 32'd88);
    check("3c_bits", 32'(pack_cap(11, 8)), 32'(11'b00011110011));
    held_err = 0;
    for (int i = 0; i < 88 && i < cap_n; i++) if (cap[i] !== cap[(i/8)*8]) held_err++;
    check("3c_hold", 32'(held_err), 32'd0);

    // Requests mid-frame and on the Busy-falling edge are dropped
    @(negedge CLK);
    P_DATA = 8'h5A; PAR_EN = 1'b0; PRESCALE = 6'd2; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    P_DATA = 8'hFF; PRESCALE = 6'd1; PAR_EN = 1'b1; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (13) @(negedge CLK);
    P_DATA = 8'hFF; DATA_VALID = 1'b1;
    @(negedge CLK);
    check("fall_edge_busy", 32'(Busy), 32'd0);
    check("fall_edge_tx", 32'(TX_OUT), 32'd1);
    P_DATA = 8'h0F; PRESCALE = 6'd2; PAR_EN = 1'b0;
    @(negedge CLK);
    check("next_accept_busy", 32'(Busy), 32'd1);
    check("next_accept_tx", 32'(TX_OUT), 32'd0);
    DATA_VALID = 1'b0;
    capture(1'b0);
    check("next_frame_len", 32'(cap_n), 32'd20);
    check("next_frame_bits", 32'(pack_cap(10, 2)), 32'(10'b0111100001));

    // Reset during the fourth data bit, then a fresh 0x01 frame
    @(negedge CLK);
    P_DATA = 8'hC3; PAR_EN = 1'b0; PRESCALE = 6'd4; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    repeat (17) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("midrst_tx", 32'(TX_OUT), 32'd1);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_state", 32'(o_dbg_state), 32'd0);
    P_DATA = 8'h01; PAR_EN = 1'b0; PRESCALE = 6'd1; DATA_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_ignores_req", 32'(Busy), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    capture(1'b0);
    check("post_rst_len", 32'(cap_n), 32'd10);
    check("post_rst_bits", 32'(pack_cap(10, 1)), 32'(10'b0100000001));

    // Prescale of zero acts as one
    send(8'h80, 1'b0, 1'b0, 6'd0, 1'b0);
    check("p0_len", 32'(cap_n), 32'd10);
    check("p0_bits", 32'(pack_cap(10, 1)), 32'(10'b0000000011));
    check("p0_msb_9th", 32'(cap[8]), 32'd1);

    // Randomized frames with noisy inputs while busy
    for (int k = 0; k < 25; k++) begin
      logic [7:0] d;
      logic       pe, pt;
      logic [5:0] ps;
      d  = 8'($urandom_range(0, 255));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      ps = 6'($urandom_range(0, 5));
      send(d, pe, pt, ps, 1'b1);
      len = (pe ? 11 : 10) * ((ps == 6'd0) ? 1 : int'(ps));
      check("rand_len", 32'(cap_n), 32'(len));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
